pixel_source_fifo: RTL and testbench

Source-side responder for the four-way pixel contention tree; one instance per pixel lane, four in total, feeding the arbiter's pix_in_N/fill_N/ack_N inputs.
- Buffers pixels from a rasterizer lane in a circular FIFO.
- Publishes its occupancy so the arbiter can choose the fullest lane.
- On the arbiter's req, returns exactly one pixel per request with a single-cycle ack.

---
 rtl/zbuf_pkg.sv | 7 +
 rtl/pixel_fifo_ram.sv | 20 ++
 rtl/pixel_source_fifo.sv | 67 ++++++
 tb/tb_pixel_source_fifo.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/zbuf_pkg.sv
// zbuf_pkg: shared pixel-path constants, pixel type and source-FSM states
package zbuf_pkg;
  localparam int DEF_PIXEL_WIDTH = 8;
  localparam int DEF_LENGTH = 8;
  typedef logic [DEF_PIXEL_WIDTH-1:0] pixel_t;
  typedef enum logic [1:0] {IDLE = 2'd0, ACK = 2'd1, WAIT = 2'd2} src_state_t;
endpackage

// File: rtl/pixel_fifo_ram.sv
// pixel_fifo_ram: DEPTH x PIXEL_WIDTH storage, synchronous write, asynchronous read
// Ports: clk; we/waddr/wdata write port; raddr/rdata combinational read port.
// No reset: the owner's pointers and fill count define which entries are valid.
module pixel_fifo_ram #(
  parameter int PIXEL_WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [PIXEL_WIDTH-1:0] wdata,
  input  logic [AW-1:0]          raddr,
  output logic [PIXEL_WIDTH-1:0] rdata
);
  logic [PIXEL_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/pixel_source_fifo.sv
// pixel_source_fifo: per-lane pixel FIFO answering arbiter requests one pixel per req
// Ports: clk, rst (async, active high); wr_en/pix_wr rasterizer write, full, sticky
// overflow; req from arbiter, ack one-cycle grant, pix_out registered pixel, fill occupancy.
module pixel_source_fifo
  import zbuf_pkg::*;
#(
  parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
  parameter int LENGTH = DEF_LENGTH,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [PIXEL_WIDTH-1:0] pix_wr,
  output logic                   full,
  output logic                   overflow,
  input  logic                   req,
  output logic                   ack,
  output logic [PIXEL_WIDTH-1:0] pix_out,
  output logic [LENGTH-1:0]      fill
);
  localparam int AW = $clog2(DEPTH);
  src_state_t state_q, state_d;
  logic [AW-1:0] rptr, wptr;
  logic [PIXEL_WIDTH-1:0] rdata;
  logic pop, push;
  assign full = fill == LENGTH'(DEPTH);
  // Occupancy is the registered value, so a fresh write can never be popped in its own cycle.
  assign pop = state_q == IDLE && req && fill != '0;
  assign push = wr_en && !full;
  // WAIT holds until req drops so a held req is served only once.
  always_comb begin
    state_d = IDLE;
    state_d = state_q == IDLE ? (pop ? ACK : IDLE) :
              state_q == ACK  ? WAIT :
              (state_q == WAIT && req) ? WAIT : IDLE;
  end
  pixel_fifo_ram #(.PIXEL_WIDTH(PIXEL_WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk(clk),
    .we(push),
    .waddr(wptr),
    .wdata(pix_wr),
    .raddr(rptr),
    .rdata(rdata)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ack      <= 1'b0;
      pix_out  <= '0;
      fill     <= '0;
      overflow <= 1'b0;
      rptr     <= '0;
      wptr     <= '0;
    end else begin
      state_q <= state_d;
      ack     <= pop;
      if (pop) begin
        pix_out <= rdata;
        rptr    <= rptr == AW'(DEPTH - 1) ? '0 : rptr + AW'(1);
      end
      if (push) wptr <= wptr == AW'(DEPTH - 1) ? '0 : wptr + AW'(1);
      if (wr_en && full) overflow <= 1'b1;
      fill <= (push && !pop) ? fill + LENGTH'(1) : (pop && !push) ? fill - LENGTH'(1) : fill;
    end
  end
endmodule

// File: tb/tb_pixel_source_fifo.sv
// tb_pixel_source_fifo: directed plus random checks of pixel_source_fifo against a queue model
module tb_pixel_source_fifo;
  import zbuf_pkg::*;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0;
  logic req = 1'b0;
  pixel_t pix_wr = '0;
  logic full, overflow, ack;
  pixel_t pix_out;
  logic [7:0] fill;
  int errors = 0;
  int checks = 0;
  pixel_t q[$];
  pixel_t m_pix = '0;
  bit m_ack = 0;
  bit m_hold = 0;
  bit m_ovf = 0;
  always #5 clk = ~clk;
  pixel_source_fifo #(.PIXEL_WIDTH(8), .LENGTH(8), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .pix_wr(pix_wr),
    .full(full),
    .overflow(overflow),
    .req(req),
    .ack(ack),
    .pix_out(pix_out),
    .fill(fill)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_all();
    chk("ack", 32'(ack), 32'(m_ack));
    chk("fill", 32'(fill), 32'(q.size()));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("pix_out", 32'(pix_out), 32'(m_pix));
  endtask
  task automatic model_reset();
    q.delete();
    m_pix = '0;
    m_ack = 0;
    m_hold = 0;
    m_ovf = 0;
  endtask
  // One clock edge: the model applies the served-once-per-req rule to the inputs seen at the edge.
  task automatic cycle();
    bit pop, acc;
    @(posedge clk);
    #1;
    pop = 0;
    if (m_ack) begin
      m_ack = 0;
      m_hold = 1;
    end else if (m_hold) begin
      if (!req) m_hold = 0;
    end else if (req && q.size() > 0) pop = 1;
    acc = wr_en && q.size() < DEPTH;
    if (wr_en && !acc) m_ovf = 1;
    if (pop) begin
      m_pix = q.pop_front();
      m_ack = 1;
    end
    if (acc) q.push_back(pix_wr);
    chk_all();
  endtask
  task automatic wr(input pixel_t p);
    wr_en = 1'b1;
    pix_wr = p;
    cycle();
    wr_en = 1'b0;
  endtask
  task automatic pulse();
    req = 1'b1;
    cycle();
    req = 1'b0;
    cycle();
    cycle();
  endtask
  initial begin
    #12;
    model_reset();
    chk_all();
    rst = 1'b0;
    wr(8'h3C);
    req = 1'b1;
    cycle();
    chk("single_ack", 32'(ack), 32'h1);
    chk("single_pix", 32'(pix_out), 32'h3C);
    req = 1'b0;
    cycle();
    cycle();
    wr(8'h11);
    wr(8'h22);
    wr(8'h33);
    req = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    chk("held_fill", 32'(fill), 32'd2);
    chk("held_pix", 32'(pix_out), 32'h11);
    req = 1'b0;
    cycle();
    req = 1'b1;
    cycle();
    chk("rereq_pix", 32'(pix_out), 32'h22);
    req = 1'b0;
    cycle();
    cycle();
    pulse();
    for (int i = 0; i <= 16; i++) wr(8'(i));
    chk("full_fill", 32'(fill), 32'd16);
    chk("full_flag", 32'(full), 32'h1);
    chk("full_ovf", 32'(overflow), 32'h1);
    for (int i = 0; i < 16; i++) begin
      req = 1'b1;
      cycle();
      chk("drain_pix", 32'(pix_out), 32'(i));
      req = 1'b0;
      cycle();
      cycle();
    end
    chk("drain_fill", 32'(fill), 32'd0);
    for (int i = 0; i < 4; i++) wr(8'hA0 + 8'(i));
    req = 1'b1;
    wr_en = 1'b1;
    pix_wr = 8'hA4;
    cycle();
    wr_en = 1'b0;
    req = 1'b0;
    chk("pushpop_fill", 32'(fill), 32'd4);
    cycle();
    cycle();
    for (int i = 0; i < 4; i++) pulse();
    req = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    chk("empty_ack", 32'(ack), 32'h0);
    wr(8'hA5);
    cycle();
    chk("late_ack", 32'(ack), 32'h1);
    chk("late_pix", 32'(pix_out), 32'hA5);
    req = 1'b0;
    cycle();
    cycle();
    for (int i = 0; i < 6; i++) wr($urandom_range(0, 255));
    req = 1'b1;
    cycle();
    chk("pre_rst_ack", 32'(ack), 32'h1);
    chk("pre_rst_fill", 32'(fill), 32'd5);
    #1 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_fill", 32'(fill), 32'h0);
    chk("rst_ovf", 32'(overflow), 32'h0);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    req = 1'b0;
    for (int i = 0; i < 600; i++) begin
      wr_en = $urandom_range(0, 99) < 55;
      pix_wr = 8'($urandom);
      req = $urandom_range(0, 99) < 45;
      cycle();
    end
    wr_en = 1'b0;
    req = 1'b0;
    cycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
